axil_arb2: RTL and testbench

Two-master to one-slave AXI4-Lite arbiter. It shares a single axil2reg register bridge, or any AXI-Lite slave, between two requesters, such as a CPU and a DMA/debug master.
- Read and write directions are arbitrated independently, each with round-robin fairness.
- Each direction has at most one transaction in flight.
- Pure routing plus small FSMs: no data buffering, no address decode.

---
 rtl/axil_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 18 +
 rtl/axil_arb2.sv | 219 +++++++++++++++++++++
 tb/tb_axil_arb2.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// rtl/axil_arb_pkg.sv - shared state types and constants for the two-master AXI-Lite arbiter
package axil_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick; on a tie the master that did not go last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/axil_arb2.sv
// rtl/axil_arb2.sv - two-master to one-slave AXI4-Lite arbiter, independent read/write round-robin
module axil_arb2
  import axil_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [NUM_MASTERS*3-1:0]          s_axil_arprot,
  input  logic [NUM_MASTERS-1:0]            s_axil_arvalid,
  output logic [NUM_MASTERS-1:0]            s_axil_arready,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axil_rdata,
  output logic [NUM_MASTERS*2-1:0]          s_axil_rresp,
  output logic [NUM_MASTERS-1:0]            s_axil_rvalid,
  input  logic [NUM_MASTERS-1:0]            s_axil_rready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [NUM_MASTERS*3-1:0]          s_axil_awprot,
  input  logic [NUM_MASTERS-1:0]            s_axil_awvalid,
  output logic [NUM_MASTERS-1:0]            s_axil_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic [NUM_MASTERS-1:0]            s_axil_wvalid,
  output logic [NUM_MASTERS-1:0]            s_axil_wready,
  output logic [NUM_MASTERS*2-1:0]          s_axil_bresp,
  output logic [NUM_MASTERS-1:0]            s_axil_bvalid,
  input  logic [NUM_MASTERS-1:0]            s_axil_bready,

  output logic [ADDR_WIDTH-1:0]             m_axil_araddr,
  output logic [2:0]                        m_axil_arprot,
  output logic                              m_axil_arvalid,
  input  logic                              m_axil_arready,
  input  logic [DATA_WIDTH-1:0]             m_axil_rdata,
  input  logic [1:0]                        m_axil_rresp,
  input  logic                              m_axil_rvalid,
  output logic                              m_axil_rready,
  output logic [ADDR_WIDTH-1:0]             m_axil_awaddr,
  output logic [2:0]                        m_axil_awprot,
  output logic                              m_axil_awvalid,
  input  logic                              m_axil_awready,
  output logic [DATA_WIDTH-1:0]             m_axil_wdata,
  output logic [STRB_WIDTH-1:0]             m_axil_wstrb,
  output logic                              m_axil_wvalid,
  input  logic                              m_axil_wready,
  input  logic [1:0]                        m_axil_bresp,
  input  logic                              m_axil_bvalid,
  output logic                              m_axil_bready
);

  rd_state_t rd_state_q;
  logic      rd_gnt_q;
  logic      rd_last_q;
  wr_state_t wr_state_q;
  logic      wr_gnt_q;
  logic      wr_last_q;
  logic      aw_done_q;
  logic      w_done_q;

  logic rd_gnt_idx, rd_gnt_valid;
  logic wr_gnt_idx, wr_gnt_valid;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  rr_arb2 u_rd_arb (
    .req       (s_axil_arvalid),
    .last      (rd_last_q),
    .gnt_idx   (rd_gnt_idx),
    .gnt_valid (rd_gnt_valid)
  );

  // Write requests come from AW only; a W that arrives early just waits for its address.
  rr_arb2 u_wr_arb (
    .req       (s_axil_awvalid),
    .last      (wr_last_q),
    .gnt_idx   (wr_gnt_idx),
    .gnt_valid (wr_gnt_valid)
  );

  assign ar_hs = m_axil_arvalid & m_axil_arready;
  assign r_hs  = m_axil_rvalid  & m_axil_rready;
  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid  & m_axil_wready;
  assign b_hs  = m_axil_bvalid  & m_axil_bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rd_gnt_q   <= 1'b0;
      rd_last_q  <= 1'b1;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (rd_gnt_valid) begin
            rd_gnt_q   <= rd_gnt_idx;
            rd_state_q <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (ar_hs) rd_state_q <= RD_DATA;
        end
        RD_DATA: begin
          if (r_hs) begin
            rd_last_q  <= rd_gnt_q;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      wr_gnt_q   <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (wr_gnt_valid) begin
            wr_gnt_q   <= wr_gnt_idx;
            wr_state_q <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) wr_state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (b_hs) begin
            wr_last_q  <= wr_gnt_q;
            wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  always_comb begin
    m_axil_araddr  = '0;
    m_axil_arprot  = '0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    s_axil_arready = '0;
    s_axil_rdata   = '0;
    s_axil_rresp   = '0;
    s_axil_rvalid  = '0;
    case (rd_state_q)
      RD_ADDR: begin
        m_axil_araddr  = rd_gnt_q ? s_axil_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : s_axil_araddr[ADDR_WIDTH-1:0];
        m_axil_arprot  = rd_gnt_q ? s_axil_arprot[5:3] : s_axil_arprot[2:0];
        m_axil_arvalid = s_axil_arvalid[rd_gnt_q];
        s_axil_arready[rd_gnt_q] = m_axil_arready;
      end
      RD_DATA: begin
        if (rd_gnt_q) begin
          s_axil_rdata[2*DATA_WIDTH-1:DATA_WIDTH] = m_axil_rdata;
          s_axil_rresp[3:2] = m_axil_rresp;
        end else begin
          s_axil_rdata[DATA_WIDTH-1:0] = m_axil_rdata;
          s_axil_rresp[1:0] = m_axil_rresp;
        end
        s_axil_rvalid[rd_gnt_q] = m_axil_rvalid;
        m_axil_rready = s_axil_rready[rd_gnt_q];
      end
      default: ;
    endcase
  end

  // The done flags keep a finished AW or W from being offered or accepted twice.
  always_comb begin
    m_axil_awaddr  = '0;
    m_axil_awprot  = '0;
    m_axil_awvalid = 1'b0;
    m_axil_wdata   = '0;
    m_axil_wstrb   = '0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    s_axil_awready = '0;
    s_axil_wready  = '0;
    s_axil_bresp   = '0;
    s_axil_bvalid  = '0;
    case (wr_state_q)
      WR_DATA: begin
        m_axil_awaddr  = wr_gnt_q ? s_axil_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : s_axil_awaddr[ADDR_WIDTH-1:0];
        m_axil_awprot  = wr_gnt_q ? s_axil_awprot[5:3] : s_axil_awprot[2:0];
        m_axil_awvalid = s_axil_awvalid[wr_gnt_q] & ~aw_done_q;
        m_axil_wdata   = wr_gnt_q ? s_axil_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : s_axil_wdata[DATA_WIDTH-1:0];
        m_axil_wstrb   = wr_gnt_q ? s_axil_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                                  : s_axil_wstrb[STRB_WIDTH-1:0];
        m_axil_wvalid  = s_axil_wvalid[wr_gnt_q] & ~w_done_q;
        s_axil_awready[wr_gnt_q] = m_axil_awready & ~aw_done_q;
        s_axil_wready[wr_gnt_q]  = m_axil_wready & ~w_done_q;
      end
      WR_RESP: begin
        if (wr_gnt_q) begin
          s_axil_bresp[3:2] = m_axil_bresp;
        end else begin
          s_axil_bresp[1:0] = m_axil_bresp;
        end
        s_axil_bvalid[wr_gnt_q] = m_axil_bvalid;
        m_axil_bready = s_axil_bready[wr_gnt_q];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_arb2.sv
// tb/tb_axil_arb2.sv - directed self-checking bench for axil_arb2
module tb_axil_arb2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axil_araddr = '0;
  logic [5:0]  s_axil_arprot = '0;
  logic [1:0]  s_axil_arvalid = '0;
  logic [1:0]  s_axil_arready;
  logic [63:0] s_axil_rdata;
  logic [3:0]  s_axil_rresp;
  logic [1:0]  s_axil_rvalid;
  logic [1:0]  s_axil_rready = '0;
  logic [63:0] s_axil_awaddr = '0;
  logic [5:0]  s_axil_awprot = '0;
  logic [1:0]  s_axil_awvalid = '0;
  logic [1:0]  s_axil_awready;
  logic [63:0] s_axil_wdata = '0;
  logic [7:0]  s_axil_wstrb = '0;
  logic [1:0]  s_axil_wvalid = '0;
  logic [1:0]  s_axil_wready;
  logic [3:0]  s_axil_bresp;
  logic [1:0]  s_axil_bvalid;
  logic [1:0]  s_axil_bready = '0;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready = 1'b0;
  logic [31:0] m_axil_rdata = '0;
  logic [1:0]  m_axil_rresp = '0;
  logic        m_axil_rvalid = 1'b0;
  logic        m_axil_rready;
  logic [31:0] m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid;
  logic        m_axil_awready = 1'b0;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready = 1'b0;
  logic [1:0]  m_axil_bresp = '0;
  logic        m_axil_bvalid = 1'b0;
  logic        m_axil_bready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  axil_arb2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1);
  end

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] hs_outputs();
    return {m_axil_arvalid, m_axil_awvalid, m_axil_wvalid, m_axil_rready, m_axil_bready,
            s_axil_arready, s_axil_awready, s_axil_wready, s_axil_rvalid, s_axil_bvalid};
  endfunction

  task automatic run_read(input int m, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [1:0] resp, input int ar_wait,
                          output int lat, output int t_beg, output int t_end);
    int  t0;
    bit  seen;
    bit  stable;
    t0    = cyc;
    t_beg = cyc;
    t_end = cyc;
    seen  = 1'b0;
    s_axil_araddr[m*32 +: 32] = addr;
    s_axil_arvalid[m] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_axil_arvalid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    lat = cyc - t0;
    expect_eq("rd_ar_seen", seen, 1);
    if (!seen) return;
    stable = 1'b1;
    for (int n = 0; n < ar_wait; n++) begin
      if (m_axil_araddr !== addr || !m_axil_arvalid || s_axil_arready !== 2'b00) stable = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    expect_eq("rd_ar_hold", stable, 1);
    expect_eq("rd_araddr", m_axil_araddr, addr);
    m_axil_arready = 1'b1;
    #1;
    expect_eq("rd_arready_route", s_axil_arready, 2'b01 << m);
    @(posedge clk); #1;
    m_axil_arready = 1'b0;
    s_axil_arvalid[m] = 1'b0;
    s_axil_araddr[m*32 +: 32] = '0;
    m_axil_rdata  = rdata;
    m_axil_rresp  = resp;
    m_axil_rvalid = 1'b1;
    s_axil_rready[m] = 1'b1;
    @(negedge clk);
    expect_eq("rd_rvalid_route", s_axil_rvalid, 2'b01 << m);
    expect_eq("rd_rdata", s_axil_rdata[m*32 +: 32], rdata);
    expect_eq("rd_rresp", s_axil_rresp[m*2 +: 2], resp);
    expect_eq("rd_rready", m_axil_rready, 1);
    @(posedge clk); #1;
    t_end = cyc;
    m_axil_rvalid = 1'b0;
    s_axil_rready[m] = 1'b0;
  endtask

  task automatic run_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int rdy_wait,
                           input int b_wait, input logic [1:0] resp,
                           output int t_beg, output int t_end);
    bit early_w, aw_got, w_got, aw_hs, w_hs, stable;
    int aw_cnt, w_cnt, bcnt;
    t_beg = cyc;
    s_axil_wdata[m*32 +: 32] = data;
    s_axil_wstrb[m*4 +: 4]   = strb;
    early_w = 1'b0;
    if (w_lead > 0) s_axil_wvalid[m] = 1'b1;
    for (int n = 0; n < w_lead; n++) begin
      @(negedge clk);
      if (m_axil_wvalid || s_axil_wready != 2'b00) early_w = 1'b1;
      @(posedge clk); #1;
    end
    if (w_lead > 0) expect_eq("wr_no_early_w", early_w, 0);
    s_axil_awaddr[m*32 +: 32] = addr;
    s_axil_awvalid[m] = 1'b1;
    s_axil_wvalid[m]  = 1'b1;
    aw_got = 1'b0; w_got = 1'b0; stable = 1'b1; aw_cnt = 0; w_cnt = 0;
    for (int n = 0; n < 40 && !(aw_got && w_got); n++) begin
      @(negedge clk);
      if (m_axil_awvalid) begin
        if (m_axil_awaddr !== addr) stable = 1'b0;
        m_axil_awready = (aw_cnt >= rdy_wait);
        aw_cnt++;
      end
      if (m_axil_wvalid) begin
        if (m_axil_wdata !== data || m_axil_wstrb !== strb) stable = 1'b0;
        m_axil_wready = (w_cnt >= rdy_wait);
        w_cnt++;
      end
      #1;
      aw_hs = m_axil_awvalid && m_axil_awready;
      w_hs  = m_axil_wvalid && m_axil_wready;
      if (aw_hs) begin
        expect_eq("wr_awaddr", m_axil_awaddr, addr);
        expect_eq("wr_awready_route", s_axil_awready, 2'b01 << m);
      end
      if (w_hs) begin
        expect_eq("wr_wdata", m_axil_wdata, data);
        expect_eq("wr_wstrb", m_axil_wstrb, strb);
      end
      @(posedge clk); #1;
      if (aw_hs) begin
        aw_got = 1'b1; m_axil_awready = 1'b0; s_axil_awvalid[m] = 1'b0;
      end
      if (w_hs) begin
        w_got = 1'b1; m_axil_wready = 1'b0; s_axil_wvalid[m] = 1'b0;
      end
    end
    expect_eq("wr_aw_done", aw_got, 1);
    expect_eq("wr_w_done", w_got, 1);
    expect_eq("wr_addr_data_hold", stable, 1);
    s_axil_bready[m] = 1'b1;
    repeat (b_wait) begin
      @(posedge clk); #1;
    end
    m_axil_bvalid = 1'b1;
    m_axil_bresp  = resp;
    @(negedge clk);
    expect_eq("wr_bvalid_route", s_axil_bvalid, 2'b01 << m);
    expect_eq("wr_bresp", s_axil_bresp[m*2 +: 2], resp);
    expect_eq("wr_bready", m_axil_bready, 1);
    @(posedge clk); #1;
    t_end = cyc;
    m_axil_bvalid = 1'b0;
    bcnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (s_axil_bvalid != 2'b00) bcnt++;
      @(posedge clk); #1;
    end
    s_axil_bready[m] = 1'b0;
    expect_eq("wr_b_once", bcnt, 0);
  endtask

  initial begin
    int cnt[2];
    int grants, g, lat, rb, re, wb, we;
    bit ar_hs, r_hs;

    // reset with every input asserted: nothing may leak through
    s_axil_arvalid = 2'b11; s_axil_awvalid = 2'b11; s_axil_wvalid = 2'b11;
    s_axil_rready = 2'b11; s_axil_bready = 2'b11;
    m_axil_arready = 1'b1; m_axil_awready = 1'b1; m_axil_wready = 1'b1;
    m_axil_rvalid = 1'b1; m_axil_bvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_eq("reset_outputs", hs_outputs(), 15'h0);
    @(posedge clk); #1;
    s_axil_arvalid = '0; s_axil_awvalid = '0; s_axil_wvalid = '0;
    s_axil_rready = '0; s_axil_bready = '0;
    m_axil_arready = 1'b0; m_axil_awready = 1'b0; m_axil_wready = 1'b0;
    m_axil_rvalid = 1'b0; m_axil_bvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // contended reads, 4 per master, must alternate starting with master 0
    cnt[0] = 0; cnt[1] = 0; grants = 0; g = 0;
    s_axil_araddr = {32'h8, 32'h4};
    s_axil_arvalid = 2'b11;
    s_axil_rready = 2'b11;
    m_axil_arready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      ar_hs = m_axil_arvalid;
      r_hs  = m_axil_rvalid && m_axil_rready;
      if (ar_hs) begin
        expect_eq("rr_gnt", s_axil_arready, (grants % 2 == 0) ? 2'b01 : 2'b10);
        g = s_axil_arready[1] ? 1 : 0;
        expect_eq("rr_araddr", m_axil_araddr, (g == 1) ? 32'h8 : 32'h4);
      end
      if (r_hs) begin
        expect_eq("rr_rvalid", s_axil_rvalid, (g == 1) ? 2'b10 : 2'b01);
        expect_eq("rr_rdata", s_axil_rdata[g*32 +: 32], (g == 1) ? 32'h8 : 32'h4);
      end
      @(posedge clk); #1;
      if (ar_hs) begin
        cnt[g]++;
        grants++;
        if (cnt[g] == 4) s_axil_arvalid[g] = 1'b0;
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = (g == 1) ? 32'h8 : 32'h4;
        m_axil_rresp  = 2'b00;
      end else if (r_hs) begin
        m_axil_rvalid = 1'b0;
      end
      if (grants == 8 && !m_axil_rvalid) break;
    end
    expect_eq("rr_total_grants", grants, 8);
    expect_eq("rr_master0_count", cnt[0], 4);
    s_axil_arvalid = '0; s_axil_araddr = '0; s_axil_rready = '0;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;

    // single read, one cycle of arbitration latency
    run_read(0, 32'h10, 32'hDEAD_BEEF, 2'b00, 0, lat, rb, re);
    expect_eq("rd_single_latency", lat, 1);

    // W offered three cycles ahead of AW by master 1
    run_write(1, 32'h20, 32'h1234_5678, 4'hF, 3, 0, 0, 2'b00, wb, we);

    // master 0 writes while master 1 reads
    fork
      run_write(0, 32'h0, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 2'b00, wb, we);
      run_read(1, 32'h0, 32'hCAFE_F00D, 2'b00, 0, lat, rb, re);
    join
    expect_eq("rd_wr_overlap", (rb <= we) && (wb <= re), 1);

    // stalled slave returning SLVERR
    run_read(0, 32'h30, 32'h0BAD_0BAD, 2'b10, 5, lat, rb, re);
    run_write(0, 32'h34, 32'h0000_0055, 4'h3, 0, 5, 5, 2'b10, wb, we);

    // reset after AW but before W; master 0 went last on both directions
    s_axil_awaddr[31:0] = 32'h40; s_axil_awvalid = 2'b01;
    s_axil_wdata[31:0] = 32'h77; s_axil_wstrb[3:0] = 4'hF; s_axil_wvalid = 2'b01;
    m_axil_awready = 1'b1; m_axil_wready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_axil_awvalid = 2'b00; m_axil_awready = 1'b0;
    @(negedge clk);
    expect_eq("mid_aw_gated", m_axil_awvalid, 0);
    expect_eq("mid_w_pending", m_axil_wvalid, 1);
    m_axil_wready = 1'b1; m_axil_arready = 1'b1;
    m_axil_rvalid = 1'b1; m_axil_bvalid = 1'b1;
    s_axil_arvalid = 2'b11; s_axil_rready = 2'b11; s_axil_bready = 2'b11;
    rst = 1'b1;
    #1;
    expect_eq("rst_async_outputs", hs_outputs(), 15'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_eq("rst_hold_outputs", hs_outputs(), 15'h0);
    m_axil_rvalid = 1'b0; m_axil_bvalid = 1'b0;
    s_axil_rready = 2'b00; s_axil_bready = 2'b00;
    s_axil_araddr = {32'h60, 32'h50};
    s_axil_awaddr = {32'h64, 32'h54};
    s_axil_awvalid = 2'b11; s_axil_wvalid = 2'b11;
    m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_arready = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    expect_eq("post_rst_rd_gnt", s_axil_arready, 2'b01);
    expect_eq("post_rst_araddr", m_axil_araddr, 32'h50);
    expect_eq("post_rst_wr_gnt", s_axil_awready, 2'b01);
    expect_eq("post_rst_awaddr", m_axil_awaddr, 32'h54);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
